motion_bbox_tracker: RTL and testbench

- Consumes the per-pixel binary motion mask from the motion-detection stage (grey-level 0 or 1020 on its red channel) and accumulates a per-frame motion pixel count and bounding box.
- Commits the results at end of frame.
- Overlays the last committed box in red on the pass-through video, one cycle late, feeding the VGA output path.

---
 rtl/motion_bbox_tracker.sv | 168 ++++++++++++++++
 tb/tb_motion_bbox_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_tracker.sv
// motion_bbox_tracker
//   Accumulates a per-frame motion-pixel count and bounding box from the
//   binary motion mask. Results are committed at end of frame. The last
//   committed box is drawn in red over the pass-through video, which is
//   delayed by one cycle.
// Ports
//   iCLK, iRST_N              pixel clock, async active-low reset
//   iFRAME_START              one-cycle start-of-frame pulse
//   iDVAL, iMASK              pixel valid and motion mask value
//   iRed/iGreen/iBlue         video to overlay
//   oDVAL, oRed/oGreen/oBlue  overlaid video, 1-cycle latency
//   oX_MIN..oY_MAX, oCOUNT    committed box and motion-pixel count
//   oBOX_VALID, oFRAME_DONE   committed box valid, commit pulse
module motion_bbox_tracker #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int MASK_THRESH = 512,
  parameter int MIN_PIXELS  = 64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFRAME_START,
  input  logic        iDVAL,
  input  logic [9:0]  iMASK,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  output logic        oDVAL,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic [9:0]  oX_MIN,
  output logic [9:0]  oX_MAX,
  output logic [9:0]  oY_MIN,
  output logic [9:0]  oY_MAX,
  output logic [18:0] oCOUNT,
  output logic        oBOX_VALID,
  output logic        oFRAME_DONE
);
  typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  THRESH = 10'(MASK_THRESH);
  localparam logic [18:0] MIN_PX = 19'(MIN_PIXELS);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [18:0] cnt_q, cnt_d;
  logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [9:0]  px_q, px_d, py_q, py_d;
  logic        dval_q, dval_d;
  logic [9:0]  red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [9:0]  bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [9:0]  by_min_q, by_min_d, by_max_q, by_max_d;
  logic [18:0] ocnt_q, ocnt_d;
  logic        bvld_q, bvld_d, done_q, done_d;

  // Accumulation base: a start pulse clears the accumulators in the same
  // cycle so a coincident pixel becomes pixel (0,0) of the new frame.
  logic [9:0]  bx, by, bxmin, bxmax, bymin, bymax, pxb, pyb;
  logic [18:0] bcnt;
  logic        acc_on, motion, on_col, on_row, draw;

  always_comb begin
    state_d = state_q;
    acc_on  = iFRAME_START || (state_q == ACTIVE);
    motion  = iMASK >= THRESH;
    bx      = iFRAME_START ? 10'd0    : x_q;
    by      = iFRAME_START ? 10'd0    : y_q;
    bcnt    = iFRAME_START ? 19'd0    : cnt_q;
    bxmin   = iFRAME_START ? 10'd1023 : xmin_q;
    bxmax   = iFRAME_START ? 10'd0    : xmax_q;
    bymin   = iFRAME_START ? 10'd1023 : ymin_q;
    bymax   = iFRAME_START ? 10'd0    : ymax_q;
    x_d = x_q;  y_d = y_q;  cnt_d = cnt_q;
    xmin_d = xmin_q;  xmax_d = xmax_q;  ymin_d = ymin_q;  ymax_d = ymax_q;

    case (state_q)
      IDLE:    if (iFRAME_START) state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      COMMIT:  state_d = iFRAME_START ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase

    if (acc_on) begin
      x_d = bx;  y_d = by;  cnt_d = bcnt;
      xmin_d = bxmin;  xmax_d = bxmax;  ymin_d = bymin;  ymax_d = bymax;
      if (iDVAL) begin
        x_d = (bx == X_LAST) ? 10'd0 : bx + 10'd1;
        if (bx == X_LAST) y_d = (by == Y_LAST) ? 10'd0 : by + 10'd1;
        if (motion) begin
          cnt_d  = (bcnt == 19'h7FFFF) ? bcnt : bcnt + 19'd1;
          xmin_d = (bx < bxmin) ? bx : bxmin;
          xmax_d = (bx > bxmax) ? bx : bxmax;
          ymin_d = (by < bymin) ? by : bymin;
          ymax_d = (by > bymax) ? by : bymax;
        end
        if (bx == X_LAST && by == Y_LAST) state_d = COMMIT;
      end
    end

    // Committed outputs are registered on entry to COMMIT so they are
    // presented, with the done pulse, during the COMMIT cycle itself.
    ocnt_d   = ocnt_q;   bvld_d   = bvld_q;
    bx_min_d = bx_min_q; bx_max_d = bx_max_q;
    by_min_d = by_min_q; by_max_d = by_max_q;
    done_d   = (state_d == COMMIT);
    if (done_d) begin
      ocnt_d = cnt_d;
      bvld_d = cnt_d >= MIN_PX;
      if (cnt_d >= MIN_PX) begin
        bx_min_d = xmin_d; bx_max_d = xmax_d;
        by_min_d = ymin_d; by_max_d = ymax_d;
      end
    end

    // Draw counter runs in every state, independent of accumulation.
    pxb  = iFRAME_START ? 10'd0 : px_q;
    pyb  = iFRAME_START ? 10'd0 : py_q;
    px_d = pxb;
    py_d = pyb;
    if (iDVAL) begin
      px_d = (pxb == X_LAST) ? 10'd0 : pxb + 10'd1;
      if (pxb == X_LAST) py_d = (pyb == Y_LAST) ? 10'd0 : pyb + 10'd1;
    end
    on_col = (pxb == bx_min_q || pxb == bx_max_q) && pyb >= by_min_q && pyb <= by_max_q;
    on_row = (pyb == by_min_q || pyb == by_max_q) && pxb >= bx_min_q && pxb <= bx_max_q;
    draw   = bvld_q && iDVAL && (on_col || on_row);
    dval_d = iDVAL;
    red_d  = draw ? 10'd1023 : iRed;
    grn_d  = draw ? 10'd0    : iGreen;
    blu_d  = draw ? 10'd0    : iBlue;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      x_q <= '0;  y_q <= '0;  cnt_q <= '0;
      xmin_q <= 10'd1023;  xmax_q <= '0;  ymin_q <= 10'd1023;  ymax_q <= '0;
      px_q <= '0;  py_q <= '0;
      dval_q <= 1'b0;  red_q <= '0;  grn_q <= '0;  blu_q <= '0;
      bx_min_q <= '0;  bx_max_q <= '0;  by_min_q <= '0;  by_max_q <= '0;
      ocnt_q <= '0;  bvld_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q <= x_d;  y_q <= y_d;  cnt_q <= cnt_d;
      xmin_q <= xmin_d;  xmax_q <= xmax_d;  ymin_q <= ymin_d;  ymax_q <= ymax_d;
      px_q <= px_d;  py_q <= py_d;
      dval_q <= dval_d;  red_q <= red_d;  grn_q <= grn_d;  blu_q <= blu_d;
      bx_min_q <= bx_min_d;  bx_max_q <= bx_max_d;
      by_min_q <= by_min_d;  by_max_q <= by_max_d;
      ocnt_q <= ocnt_d;  bvld_q <= bvld_d;  done_q <= done_d;
    end
  end

  assign oDVAL       = dval_q;
  assign oRed        = red_q;
  assign oGreen      = grn_q;
  assign oBlue       = blu_q;
  assign oX_MIN      = bx_min_q;
  assign oX_MAX      = bx_max_q;
  assign oY_MIN      = by_min_q;
  assign oY_MAX      = by_max_q;
  assign oCOUNT      = ocnt_q;
  assign oBOX_VALID  = bvld_q;
  assign oFRAME_DONE = done_q;
endmodule

// File: tb/tb_motion_bbox_tracker.sv
// Scoreboard bench for motion_bbox_tracker on an 8x4 frame, MIN_PIXELS=3.
module tb_motion_bbox_tracker;
  localparam int H = 8;
  localparam int V = 4;

  logic        iCLK = 1'b0, iRST_N = 1'b0, iFRAME_START = 1'b0, iDVAL = 1'b0;
  logic [9:0]  iMASK = '0, iRed = '0, iGreen = '0, iBlue = '0;
  logic        oDVAL, oBOX_VALID, oFRAME_DONE;
  logic [9:0]  oRed, oGreen, oBlue, oX_MIN, oX_MAX, oY_MIN, oY_MAX;
  logic [18:0] oCOUNT;

  motion_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MASK_THRESH(512), .MIN_PIXELS(3)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFRAME_START(iFRAME_START), .iDVAL(iDVAL),
    .iMASK(iMASK), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oDVAL(oDVAL), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN), .oY_MAX(oY_MAX),
    .oCOUNT(oCOUNT), .oBOX_VALID(oBOX_VALID), .oFRAME_DONE(oFRAME_DONE));

  always #5 iCLK = ~iCLK;

  typedef struct { int cnt; int vld; int x0; int x1; int y0; int y1; } commit_t;
  typedef struct { int r; int g; int b; } pix_t;

  commit_t exp_c[$];
  pix_t    exp_p[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Box currently drawn by the overlay, as the bench expects it.
  int ov_v = 0, ov_x0 = 0, ov_x1 = 0, ov_y0 = 0, ov_y1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic pix_t exp_colour(input int x, input int y);
    pix_t p;
    logic e;
    e = ov_v != 0 &&
        (((x == ov_x0 || x == ov_x1) && y >= ov_y0 && y <= ov_y1) ||
         ((y == ov_y0 || y == ov_y1) && x >= ov_x0 && x <= ov_x1));
    p.r = e ? 1023 : 100;
    p.g = e ? 0 : 100;
    p.b = e ? 0 : 100;
    return p;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oFRAME_DONE) begin
        if (exp_c.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          commit_t c;
          c = exp_c.pop_front();
          chk("count", int'(oCOUNT), c.cnt);
          chk("box_valid", int'(oBOX_VALID), c.vld);
          chk("x_min", int'(oX_MIN), c.x0);
          chk("x_max", int'(oX_MAX), c.x1);
          chk("y_min", int'(oY_MIN), c.y0);
          chk("y_max", int'(oY_MAX), c.y1);
        end
      end
      if (oDVAL) begin
        if (exp_p.size() == 0) chk("unexpected_dval", 1, 0);
        else begin
          pix_t p;
          p = exp_p.pop_front();
          if (int'(oRed) != p.r || int'(oGreen) != p.g || int'(oBlue) != p.b) begin
            n_tests++; n_fail++;
            $display("FAIL overlay: got %0d/%0d/%0d want %0d/%0d/%0d",
                     oRed, oGreen, oBlue, p.r, p.g, p.b);
          end else n_tests++;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK); #1;
      iFRAME_START = 1'b0; iDVAL = 1'b0; iMASK = '0;
    end
  endtask

  task automatic pix(input logic start, input logic [9:0] m, input int x, input int y,
                     input logic push);
    @(posedge iCLK); #1;
    iFRAME_START = start; iDVAL = 1'b1; iMASK = m;
    iRed = 10'd100; iGreen = 10'd100; iBlue = 10'd100;
    if (push) exp_p.push_back(exp_colour(x, y));
  endtask

  // One full frame. hot pixels get mval, lo pixels get 511, others 0.
  // sep: separate start pulse, else start coincides with pixel (0,0).
  task automatic frame(input logic sep, input logic gaps, input logic [31:0] hot,
                       input logic [9:0] mval, input logic [31:0] lo);
    logic [9:0] m;
    if (sep) begin
      @(posedge iCLK); #1;
      iFRAME_START = 1'b1; iDVAL = 1'b0;
    end
    for (int i = 0; i < H * V; i++) begin
      if (gaps && (i % H) == 4) idle(3);
      m = hot[i] ? mval : (lo[i] ? 10'd511 : 10'd0);
      pix(!sep && i == 0, m, i % H, i / H, 1'b1);
    end
    idle(1);
  endtask

  function automatic commit_t mk(input int c, input int v, input int a, input int b,
                                 input int d, input int e);
    commit_t r;
    r.cnt = c; r.vld = v; r.x0 = a; r.x1 = b; r.y0 = d; r.y1 = e;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_dval"}, int'(oDVAL), 0);
    chk({tag, "_rgb"}, int'(oRed) + int'(oGreen) + int'(oBlue), 0);
    chk({tag, "_box"}, int'(oX_MIN) + int'(oX_MAX) + int'(oY_MIN) + int'(oY_MAX), 0);
    chk({tag, "_count"}, int'(oCOUNT), 0);
    chk({tag, "_valid"}, int'(oBOX_VALID), 0);
    chk({tag, "_done"}, int'(oFRAME_DONE), 0);
  endtask

  initial begin
    #30; check_all_zero("reset");
    @(posedge iCLK); #1; iRST_N = 1'b1;
    idle(2);

    // F1: separate start pulse, motion at (2,1),(5,1),(3,2).
    exp_c.push_back(mk(3, 1, 2, 5, 1, 2));
    frame(1'b1, 1'b0, (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 19), 10'd1020, 32'd0);
    idle(3);
    ov_v = 1; ov_x0 = 2; ov_x1 = 5; ov_y0 = 1; ov_y1 = 2;

    // F2: 2 motion pixels, overlay of F1 box drawn, box registers held.
    exp_c.push_back(mk(2, 0, 2, 5, 1, 2));
    frame(1'b1, 1'b0, (32'd1 << 24) | (32'd1 << 7), 10'd1020, 32'd0);
    idle(3);
    ov_v = 0;

    // F3: threshold edge with 3-cycle gaps mid-line, no overlay.
    exp_c.push_back(mk(3, 1, 1, 7, 0, 3));
    frame(1'b1, 1'b1, (32'd1 << 1) | (32'd1 << 31) | (32'd1 << 20), 10'd512,
          (32'd1 << 27) | 32'd1);
    idle(3);
    ov_v = 1; ov_x0 = 1; ov_x1 = 7; ov_y0 = 0; ov_y1 = 3;

    // F4: same frame without gaps gives the same result.
    exp_c.push_back(mk(3, 1, 1, 7, 0, 3));
    frame(1'b0, 1'b0, (32'd1 << 1) | (32'd1 << 31) | (32'd1 << 20), 10'd512,
          (32'd1 << 27) | 32'd1);
    idle(3);

    // Abandoned partial frame of 20 motion pixels, then restart with a
    // same-cycle start+motion pixel at (0,0).
    for (int i = 0; i < 20; i++) pix(i == 0, 10'd1020, i % H, i / H, 1'b1);
    exp_c.push_back(mk(3, 1, 0, 6, 0, 2));
    frame(1'b0, 1'b0, 32'd1 | (32'd1 << 11) | (32'd1 << 22), 10'd1020, 32'd0);
    idle(3);
    ov_v = 1; ov_x0 = 0; ov_x1 = 6; ov_y0 = 0; ov_y1 = 2;

    // Reset at pixel 10 of a frame.
    for (int i = 0; i < 10; i++) pix(i == 0, 10'd1020, i % H, i / H, 1'b1);
    pix(1'b0, 10'd1020, 10 % H, 10 / H, 1'b0);
    @(negedge iCLK); #1; iRST_N = 1'b0;
    #1; check_all_zero("midreset");
    pix(1'b0, 10'd1020, 0, 0, 1'b0);
    @(posedge iCLK); #1; iRST_N = 1'b1; iDVAL = 1'b0;
    ov_v = 0;
    for (int i = 0; i < 5; i++) pix(1'b0, 10'd1020, i, 0, 1'b1);
    idle(3);
    chk("ignored_count", int'(oCOUNT), 0);
    chk("ignored_valid", int'(oBOX_VALID), 0);

    // F6: full frame after reset accumulates only its own pixels.
    exp_c.push_back(mk(3, 1, 1, 6, 1, 3));
    frame(1'b1, 1'b0, (32'd1 << 9) | (32'd1 << 18) | (32'd1 << 30), 10'd1020, 32'd0);
    idle(4);

    chk("pending_commits", exp_c.size(), 0);
    chk("pending_pixels", exp_p.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
